life_frame_readout: RTL

Downstream consumer of the LifeCell array. On each generation tick it snapshots the grid's alive bits and streams them out one row per beat over a valid/ready handshake. The destination is a display or UART bridge. It also keeps a generation counter and flags still-life, extinction and dropped-frame (overrun) conditions for the top-level controller.

---
 rtl/life_pkg.sv | 18 +
 rtl/life_row_mux.sv | 32 +++
 rtl/life_frame_readout.sv | 114 +++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the LifeCell frame readout: FSM encoding, default
// geometry and the row-index width helper.
package life_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_GEN_W = 16;

    function automatic int row_w(input int rows);
        return (rows <= 2) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/life_row_mux.sv
// Selects one row of the captured frame for presentation on the output bus.
module life_row_mux
    import life_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int RW   = row_w(DEF_ROWS)
) (
    input  logic [ROWS*COLS-1:0] frame,
    input  logic [RW-1:0]        row,
    output logic [COLS-1:0]      data
);

    logic [COLS-1:0] rows_arr [ROWS];

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
            assign rows_arr[gi] = frame[gi*COLS +: COLS];
        end
    endgenerate

    // Indices past ROWS-1 only exist when ROWS is not a power of two.
    always_comb begin
        data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row == RW'(r)) begin
                data = rows_arr[r];
            end
        end
    end

endmodule

// File: rtl/life_frame_readout.sv
// Snapshots the LifeCell grid on each generation tick and streams it out one
// row per valid/ready beat, with generation count and frame status flags.
module life_frame_readout
    import life_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int GEN_W = DEF_GEN_W
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [ROWS*COLS-1:0]    alive_in,
    input  logic                    gen_tick,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS-1:0]         out_data,
    output logic [row_w(ROWS)-1:0]  out_row,
    output logic                    out_last,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    still_life,
    output logic                    extinct,
    output logic                    overrun
);

    localparam int RW = row_w(ROWS);

    state_t                 state_reg;
    logic [ROWS*COLS-1:0]   snap_reg;
    logic [ROWS*COLS-1:0]   prev_reg;
    logic                   first_reg;
    logic                   two_reg;
    logic [RW-1:0]          row_reg;
    logic                   valid_reg;
    logic                   last_reg;
    logic [GEN_W-1:0]       gen_reg;
    logic                   ext_reg;
    logic                   ovr_reg;

    logic handshake;
    logic last_hs;
    logic capture;
    logic drop;

    assign handshake = valid_reg && out_ready;
    assign last_hs   = handshake && last_reg;
    // A tick landing on the final handshake starts the next frame seamlessly.
    assign capture   = gen_tick && ((state_reg == ST_IDLE) || last_hs);
    assign drop      = gen_tick && (state_reg == ST_SEND) && !last_hs;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
            snap_reg  <= '0;
            prev_reg  <= '0;
            first_reg <= 1'b1;
            two_reg   <= 1'b0;
            row_reg   <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            gen_reg   <= '0;
            ext_reg   <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            if (gen_tick) begin
                gen_reg <= gen_reg + 1'b1;
            end
            if (drop) begin
                ovr_reg <= 1'b1;
            end
            if (capture) begin
                prev_reg  <= snap_reg;
                snap_reg  <= alive_in;
                ext_reg   <= (alive_in == '0);
                two_reg   <= !first_reg;
                first_reg <= 1'b0;
                state_reg <= ST_SEND;
                valid_reg <= 1'b1;
                row_reg   <= '0;
                last_reg  <= 1'b0;
            end else if ((state_reg == ST_SEND) && handshake) begin
                if (last_reg) begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    row_reg   <= '0;
                end else begin
                    row_reg  <= row_reg + 1'b1;
                    last_reg <= (row_reg == RW'(ROWS-2));
                end
            end
        end
    end

    // Old/new frame equality is kept as snapshot vs. prev; only meaningful
    // once two frames have been captured since reset.
    assign still_life = two_reg && (snap_reg == prev_reg);
    assign extinct    = ext_reg;
    assign overrun    = ovr_reg;
    assign gen_count  = gen_reg;
    assign out_valid  = valid_reg;
    assign out_row    = row_reg;
    assign out_last   = last_reg;

    life_row_mux #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW)
    ) u_row_mux (
        .frame (snap_reg),
        .row   (row_reg),
        .data  (out_data)
    );

endmodule
